// File: rtl/option_fifo_feeder.sv
// option_fifo_feeder: buffers generator line options and issues them to the solver, requeueing put-backs
module option_fifo_feeder #(
  parameter int LINE_W = 3,
  parameter int IND_W  = 5,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gen_valid,
  input  logic [IND_W-1:0]         gen_line_ind,
  input  logic [LINE_W-1:0]        gen_option,
  output logic                     gen_ready,
  input  logic                     gen_last,
  output logic                     valid_op,
  output logic [IND_W-1:0]         op_line_ind,
  output logic [LINE_W-1:0]        op_option,
  input  logic                     sol_valid_out,
  input  logic                     put_back,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     stuck
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [IND_W+LINE_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] sweep_rem;
  logic progress, requeue, gen_acc, pop;
  assign requeue   = state == WAIT && sol_valid_out && put_back;
  assign pop       = state == ISSUE;
  assign gen_ready = !rst && (count + CW'(state == WAIT)) < CW'(DEPTH) && !requeue;
  assign gen_acc   = gen_valid && gen_ready;
  assign done      = !rst && gen_last && count == '0 && state != WAIT;
  always_ff @(posedge clk)
    if (requeue || gen_acc)
      mem[wp] <= requeue ? {op_line_ind, op_option} : {gen_line_ind, gen_option};
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      valid_op    <= 1'b0;
      op_line_ind <= '0;
      op_option   <= '0;
      sweep_rem   <= '0;
      progress    <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      if (requeue || gen_acc) wp <= wp + 1'b1;
      count    <= count + CW'(requeue || gen_acc) - CW'(pop);
      valid_op <= pop;
      case (state)
        IDLE: if (count != '0 && !stuck && gen_last) state <= ISSUE;
        ISSUE: begin
          {op_line_ind, op_option} <= mem[rp];
          rp    <= rp + 1'b1;
          state <= WAIT;
          if (sweep_rem == '0) begin
            sweep_rem <= count;
            progress  <= 1'b0;
          end
        end
        WAIT: if (sol_valid_out) begin
          state     <= IDLE;
          sweep_rem <= sweep_rem - 1'b1;
          if (!put_back) progress <= 1'b1;
          if (sweep_rem == CW'(1) && !progress && put_back) stuck <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_option_fifo_feeder.sv
// tb_option_fifo_feeder: scoreboard bench checking issue order, occupancy, done and stuck
module tb_option_fifo_feeder;
  logic clk, rst, gen_valid, gen_ready, gen_last, valid_op, sol_valid_out, put_back, done, stuck;
  logic [4:0] gen_line_ind, op_line_ind;
  logic [2:0] gen_option, op_option;
  logic [6:0] count;
  logic [7:0] model [$];
  int checks, errors;

  option_fifo_feeder dut (
    .clk(clk), .rst(rst), .gen_valid(gen_valid), .gen_line_ind(gen_line_ind),
    .gen_option(gen_option), .gen_ready(gen_ready), .gen_last(gen_last),
    .valid_op(valid_op), .op_line_ind(op_line_ind), .op_option(op_option),
    .sol_valid_out(sol_valid_out), .put_back(put_back), .count(count),
    .done(done), .stuck(stuck)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1; gen_last = 0; gen_valid = 0; sol_valid_out = 0; put_back = 0;
    gen_line_ind = 0; gen_option = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model.delete();
  endtask

  task automatic push(input logic [4:0] i, input logic [2:0] o);
    gen_valid = 1; gen_line_ind = i; gen_option = o; #1;
    for (int k = 0; k < 50 && !gen_ready; k++) begin @(negedge clk); #1; end
    checks++;
    if (gen_ready !== 1'b1) begin errors++; $display("FAIL push_ready got %b want 1", gen_ready); end
    model.push_back({i, o});
    @(negedge clk);
    gen_valid = 0;
  endtask

  task automatic wait_issue();
    logic [7:0] exp;
    for (int k = 0; k < 20 && !valid_op; k++) @(negedge clk);
    checks++;
    if (valid_op !== 1'b1 || model.size() == 0) begin
      errors++; $display("FAIL issue_timeout valid_op %b model %0d want pulse", valid_op, model.size());
    end else begin
      exp = model.pop_front();
      checks++;
      if ({op_line_ind, op_option} !== exp) begin
        errors++; $display("FAIL issue_entry got %h want %h", {op_line_ind, op_option}, exp);
      end
      checks++;
      if (count !== 7'(model.size())) begin
        errors++; $display("FAIL issue_count got %0d want %0d", count, model.size());
      end
    end
  endtask

  task automatic respond(input bit pb);
    sol_valid_out = 1; put_back = pb;
    if (pb) model.push_back({op_line_ind, op_option});
    @(negedge clk);
    sol_valid_out = 0; put_back = 0;
  endtask

  task automatic test_reset();
    rst = 1; gen_last = 0; gen_valid = 0; sol_valid_out = 0; put_back = 0;
    gen_line_ind = 0; gen_option = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (gen_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", gen_ready); end
    checks++;
    if ({valid_op, done, stuck, count, op_line_ind, op_option} !== '0) begin
      errors++; $display("FAIL rst_outputs got %b%b%b %0d %h want all 0", valid_op, done, stuck, count, {op_line_ind, op_option});
    end
    @(negedge clk);
    rst = 0; #1;
    checks++;
    if (gen_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", gen_ready); end
    model.delete();
  endtask

  task automatic test_drain();
    do_reset();
    push(5'd1, 3'b001); push(5'd2, 3'b010); push(5'd3, 3'b100);
    checks++;
    if (count !== 7'd3) begin errors++; $display("FAIL drain_load_count got %0d want 3", count); end
    gen_last = 1;
    for (int n = 0; n < 3; n++) begin
      wait_issue();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL drain_done_early got %b want 0", done); end
      respond(0);
    end
    checks++;
    if (done !== 1'b1 || stuck !== 1'b0) begin
      errors++; $display("FAIL drain_done got done %b stuck %b want 1 0", done, stuck);
    end
  endtask

  task automatic test_requeue();
    do_reset();
    push(5'd4, 3'b011); push(5'd9, 3'b110);
    gen_last = 1;
    wait_issue(); respond(1);
    wait_issue(); respond(0);
    wait_issue();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL requeue_done_early got %b want 0", done); end
    respond(0);
    checks++;
    if (done !== 1'b1 || stuck !== 1'b0) begin
      errors++; $display("FAIL requeue_done got done %b stuck %b want 1 0", done, stuck);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int n = 0; n < 64; n++) push(5'(n % 32), 3'(n));
    #1;
    checks++;
    if (count !== 7'd64 || gen_ready !== 1'b0) begin
      errors++; $display("FAIL full_count got %0d ready %b want 64 0", count, gen_ready);
    end
    gen_last = 1;
    wait_issue();
    #1;
    checks++;
    if (gen_ready !== 1'b0) begin errors++; $display("FAIL full_reserved got %b want 0", gen_ready); end
    respond(0);
    #1;
    checks++;
    if (gen_ready !== 1'b1) begin errors++; $display("FAIL full_freed got %b want 1", gen_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(5'd7, 3'b101); push(5'd8, 3'b010);
    gen_last = 1;
    wait_issue();
    sol_valid_out = 1; put_back = 1;
    gen_valid = 1; gen_line_ind = 5'd12; gen_option = 3'b111;
    model.push_back({op_line_ind, op_option});
    #1;
    checks++;
    if (gen_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got %b want 0", gen_ready); end
    @(negedge clk);
    sol_valid_out = 0; put_back = 0; #1;
    checks++;
    if (gen_ready !== 1'b1 || count !== 7'd2) begin
      errors++; $display("FAIL collide_requeued got ready %b count %0d want 1 2", gen_ready, count);
    end
    model.push_back({5'd12, 3'b111});
    @(negedge clk);
    gen_valid = 0;
    checks++;
    if (count !== 7'd3) begin errors++; $display("FAIL collide_gen_count got %0d want 3", count); end
    for (int n = 0; n < 3; n++) begin wait_issue(); respond(0); end
    checks++;
    if (done !== 1'b1 || stuck !== 1'b0) begin
      errors++; $display("FAIL collide_done got done %b stuck %b want 1 0", done, stuck);
    end
  endtask

  task automatic test_stuck();
    int pulses = 0;
    do_reset();
    push(5'd2, 3'b001); push(5'd3, 3'b110);
    gen_last = 1;
    wait_issue(); respond(1);
    wait_issue(); respond(1);
    for (int k = 0; k < 12; k++) begin
      if (valid_op) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL stuck_no_issue got %0d pulses want 0", pulses); end
    checks++;
    if (stuck !== 1'b1 || done !== 1'b0 || count !== 7'd2) begin
      errors++; $display("FAIL stuck_flags got stuck %b done %b count %0d want 1 0 2", stuck, done, count);
    end
  endtask

  task automatic test_reset_wait();
    int pulses = 0;
    do_reset();
    push(5'd6, 3'b011);
    gen_last = 1;
    wait_issue();
    rst = 1; gen_last = 0;
    @(negedge clk);
    checks++;
    if (valid_op !== 1'b0 || count !== 7'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rstwait_state got valid %b count %0d done %b want 0 0 0", valid_op, count, done);
    end
    rst = 0;
    sol_valid_out = 1; put_back = 1;
    @(negedge clk);
    sol_valid_out = 0; put_back = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid_op) pulses++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (pulses !== 0 || count !== 7'd0 || stuck !== 1'b0 || gen_ready !== 1'b1) begin
      errors++; $display("FAIL rstwait_late_sol got pulses %0d count %0d stuck %b ready %b want 0 0 0 1", pulses, count, stuck, gen_ready);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_drain();
    test_requeue();
    test_full();
    test_back_to_back();
    test_stuck();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
